memory: RTL and testbench

Single-port, word-addressed synchronous RAM with a shared bidirectional data bus. It is the storage element behind the Wishbone slave. The bus master either writes a word at a 32-bit address or reads one back over the same tri-stated `data` lines. All storage is cleared by an asynchronous active-low reset.

---
 rtl/memory_pkg.sv | 10 +
 rtl/memory_array.sv | 37 +++
 rtl/memory.sv | 68 ++++++
 tb/tb_memory.sv | 133 +++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared defaults and word type for the single-port RAM behind the Wishbone slave.
package memory_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  typedef logic [DATA_W-1:0] word_t;

endpackage : memory_pkg

// File: rtl/memory_array.sv
// Plain DEPTH x DATA_W storage with one write port, one combinational read port
// and an asynchronous clear of every word.
module memory_array
  import memory_pkg::*;
#(
  parameter int DATA_W = memory_pkg::DATA_W,
  parameter int DEPTH  = memory_pkg::DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: whole array clears on reset, otherwise one word per write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read; the caller guarantees raddr is in range before using it.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule : memory_array

// File: rtl/memory.sv
// Word-addressed synchronous RAM on a shared tri-state data bus: write when wen=1,
// registered read (one cycle) driven onto the bus while wen=0.
module memory
  import memory_pkg::*;
#(
  parameter int DATA_W = memory_pkg::DATA_W,
  parameter int DEPTH  = memory_pkg::DEPTH,
  parameter int ADDR_W = memory_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic              wen,
  inout  wire  [DATA_W-1:0] data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              in_range_s;
  logic              we_s;
  logic              drive_s;
  logic [DATA_W-1:0] rdata_s;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // Range check uses the full address so high addresses never alias onto low words.
  // An unknown wen falls through to the hold branch: no write, no read, no drive.
  always_comb begin
    in_range_s = (adr < ADDR_W'(DEPTH));
    we_s       = 1'b0;
    rd_d       = rd_q;
    drive_s    = 1'b0;
    if (wen == 1'b1) begin
      we_s = in_range_s;
    end else if (wen == 1'b0) begin
      rd_d    = in_range_s ? rdata_s : {DATA_W{1'b0}};
      drive_s = reset;
    end else begin
      rd_d = rd_q;
    end
  end

  // Read register: cleared asynchronously, holds across write cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q <= {DATA_W{1'b0}};
    end else begin
      rd_q <= rd_d;
    end
  end

  memory_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clock),
    .rst_n (reset),
    .we    (we_s),
    .waddr (adr[IDX_W-1:0]),
    .wdata (data),
    .raddr (adr[IDX_W-1:0]),
    .rdata (rdata_s)
  );

  assign data = drive_s ? rd_q : {DATA_W{1'bz}};

endmodule : memory

// File: tb/tb_memory.sv
// Directed-vector bench for memory: hand-computed expectations, one checking task.
module tb_memory;
  import memory_pkg::*;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] adr;
  logic              wen;
  logic              tb_drive;
  word_t             tb_val;
  wire  [DATA_W-1:0] data;

  int n_vec;
  int n_err;

  assign data = tb_drive ? tb_val : {DATA_W{1'bz}};

  memory dut (
    .clock (clock),
    .reset (reset),
    .adr   (adr),
    .wen   (wen),
    .data  (data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write cycle; the bus must carry exactly the master's value (memory not driving).
  task automatic do_write(input logic [ADDR_W-1:0] a, input word_t v, input string tag);
    @(negedge clock);
    adr      = a;
    wen      = 1'b1;
    tb_drive = 1'b1;
    tb_val   = v;
    @(posedge clock);
    #1;
    check_eq(tag, data, v);
  endtask

  // Read cycle; the value appears on the bus just after the sampling edge.
  task automatic do_read(input logic [ADDR_W-1:0] a, input word_t exp, input string tag);
    @(negedge clock);
    adr      = a;
    wen      = 1'b0;
    tb_drive = 1'b0;
    @(posedge clock);
    #1;
    check_eq(tag, data, exp);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    adr      = {ADDR_W{1'b0}};
    wen      = 1'b0;
    tb_drive = 1'b1;
    tb_val   = 32'hA5A5_A5A5;

    // Held in reset: memory must not fight the master's pattern.
    @(posedge clock);
    #1;
    check_eq("reset_bus_free", data, 32'hA5A5_A5A5);
    @(negedge clock);
    reset = 1'b1;

    do_read(32'd0,   32'h0000_0000, "reset_rd0");
    do_read(32'd10,  32'h0000_0000, "reset_rd10");
    do_read(32'd255, 32'h0000_0000, "reset_rd255");

    do_write(32'd10, 32'hDEAD_BEEF, "bus_wr10");
    do_write(32'd11, 32'hFEED_BEEF, "bus_wr11");
    do_write(32'd12, 32'hFADE_BEED, "bus_wr12");
    do_write(32'd13, 32'hBEEF_FADE, "bus_wr13");
    do_read(32'd12, 32'hFADE_BEED, "rd12");
    do_read(32'd10, 32'hDEAD_BEEF, "rd10");
    do_read(32'd11, 32'hFEED_BEEF, "rd11");
    do_read(32'd13, 32'hBEEF_FADE, "rd13");

    // rd_q must hold across a write and show stale on the first read cycle.
    do_write(32'd20, 32'h1234_0000, "bus_wr20");
    @(negedge clock);
    adr      = 32'd10;
    wen      = 1'b0;
    tb_drive = 1'b0;
    #1;
    check_eq("stale_rdq", data, 32'hBEEF_FADE);
    @(posedge clock);
    #1;
    check_eq("rd10_after_stale", data, 32'hDEAD_BEEF);
    do_read(32'd20, 32'h1234_0000, "rd20");

    do_write(32'd256, 32'h1234_5678, "bus_wr256");
    do_read(32'd256, 32'h0000_0000, "oor_rd256");
    do_read(32'd0,   32'h0000_0000, "no_alias_rd0");
    do_read(32'h8000_0005, 32'h0000_0000, "oor_rd_high");

    do_write(32'd255, 32'h0BAD_F00D, "bus_wr255");
    do_read(32'd255, 32'h0BAD_F00D, "rd255");

    do_write(32'd5, 32'hAAAA_5555, "bus_wr5a");
    do_write(32'd5, 32'h5555_AAAA, "bus_wr5b");
    do_read(32'd5, 32'h5555_AAAA, "rd5_latest");

    // Reset asserted between edges with data already loaded.
    do_write(32'd12, 32'hFADE_BEED, "bus_wr12b");
    do_read(32'd13, 32'hBEEF_FADE, "rd13b");
    @(negedge clock);
    reset    = 1'b0;
    tb_drive = 1'b1;
    tb_val   = 32'h1111_0000;
    #1;
    check_eq("midreset_bus_free", data, 32'h1111_0000);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    do_read(32'd12, 32'h0000_0000, "post_reset_rd12");
    do_read(32'd5,  32'h0000_0000, "post_reset_rd5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_memory
